// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU sequencer controller.
package alu_seq_pkg;

    localparam int unsigned COUNT_W   = 16;
    localparam int unsigned NUM_REGS  = 32;
    localparam int unsigned REG_IDX_W = $clog2(NUM_REGS);
    localparam logic [31:0] PC_STEP   = 32'd4;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        EXEC,
        DUMP,
        DONE
    } state_e;

    // Retired-instruction counter sticks at all-ones instead of wrapping.
    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
        return (v == {COUNT_W{1'b1}}) ? v : v + COUNT_W'(1);
    endfunction

endpackage

// File: rtl/alu_seq_ctrl.sv
// Fetch/execute sequencer for a single-cycle ALU datapath with an optional
// post-run register dump, compiled in by defining ALU_SEQ_DUMP_EN.
module alu_seq_ctrl
    import alu_seq_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [COUNT_W-1:0] num_instr,
    output logic [31:0]        imem_addr,
    input  logic [31:0]        imem_rdata,
    input  logic               imem_valid,
    output logic [31:0]        instr,
    input  logic               dec_we,
    output logic               we,
    output logic               sel,
    output logic [4:0]         dump_rs1,
    output logic               dump_valid,
    output logic               busy,
    output logic               done,
    output logic [COUNT_W-1:0] instr_count
);

`ifdef ALU_SEQ_DUMP_EN
    localparam state_e RUN_END = DUMP;
`else
    localparam state_e RUN_END = DONE;
`endif

    state_e             state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic [31:0]        instr_q;
    logic [COUNT_W-1:0] count_q, count_d;
    logic [COUNT_W-1:0] numInstr_q;
    logic               busy_q, done_q;

`ifdef ALU_SEQ_DUMP_EN
    logic                 sel_q, dumpValid_q;
    logic [REG_IDX_W-1:0] dumpRs1_q;
`endif

    assign pc_d    = pc_q + PC_STEP;
    assign count_d = sat_inc(count_q);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (start) state_d = (num_instr != '0) ? FETCH : RUN_END;
            FETCH: if (imem_valid) state_d = EXEC;
            EXEC:  state_d = (count_d == numInstr_q) ? RUN_END : FETCH;
`ifdef ALU_SEQ_DUMP_EN
            DUMP:  if (dumpRs1_q == REG_IDX_W'(NUM_REGS - 1)) state_d = DONE;
`endif
            DONE:  if (!start) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            pc_q       <= '0;
            instr_q    <= '0;
            count_q    <= '0;
            numInstr_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d == FETCH) || (state_d == EXEC) || (state_d == DUMP);
            done_q  <= (state_d == DONE);
            if ((state_q == IDLE) && start) begin
                pc_q       <= '0;
                count_q    <= '0;
                numInstr_q <= num_instr;
            end
            if ((state_q == FETCH) && imem_valid) begin
                instr_q <= imem_rdata;
            end
            if (state_q == EXEC) begin
                pc_q    <= pc_d;
                count_q <= count_d;
            end
        end
    end

`ifdef ALU_SEQ_DUMP_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            sel_q       <= 1'b1;
            dumpValid_q <= 1'b0;
            dumpRs1_q   <= '0;
        end else begin
            sel_q       <= (state_d != DUMP);
            dumpValid_q <= (state_d == DUMP);
            if (state_q == DUMP) begin
                dumpRs1_q <= dumpRs1_q + REG_IDX_W'(1);
            end
        end
    end

    assign sel        = sel_q;
    assign dump_valid = dumpValid_q;
    assign dump_rs1   = dumpRs1_q;
`else
    assign sel        = 1'b1;
    assign dump_valid = 1'b0;
    assign dump_rs1   = '0;
`endif

    // Decoder write request passes straight through in EXEC; a concurrent reset kills it.
    assign we          = (state_q == EXEC) && dec_we && !reset;
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl; follows ALU_SEQ_DUMP_EN like the RTL.
module tb_alu_seq_ctrl;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] num_instr;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_valid;
    logic [31:0] instr;
    logic        dec_we;
    logic        we;
    logic        sel;
    logic [4:0]  dump_rs1;
    logic        dump_valid;
    logic        busy;
    logic        done;
    logic [15:0] instr_count;

    int checks   = 0;
    int failures = 0;
    logic [31:0] expInstrQ[$];

    alu_seq_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .num_instr  (num_instr),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_valid (imem_valid),
        .instr      (instr),
        .dec_we     (dec_we),
        .we         (we),
        .sel        (sel),
        .dump_rs1   (dump_rs1),
        .dump_valid (dump_valid),
        .busy       (busy),
        .done       (done),
        .instr_count(instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required clean finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] memWord(input logic [31:0] addr);
        return 32'hC0DE_0000 | (addr & 32'h0000_FFFF);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one whole run; DUT must be in IDLE with start low on entry.
    task automatic run_program(input int n, input int stallIdx, input int stallLat,
                               input bit decWe, input bit holdStart, input int abortIdx);
        int          lat;
        logic [31:0] addr;
        logic [31:0] exp;
        start      = 1'b1;
        num_instr  = 16'(n);
        imem_valid = 1'b0;
        dec_we     = 1'b0;
        tick();
        start     = holdStart;
        num_instr = 16'hFFFF;
        for (int i = 0; i < n; i++) begin
            addr = 32'(i * 4);
            lat  = (i == stallIdx) ? stallLat : 1;
            for (int k = 1; k <= lat; k++) begin
                imem_valid = (k == lat);
                imem_rdata = (k == lat) ? memWord(addr) : 32'hBAD0_BAD0;
                dec_we     = 1'b1;
                if (k == lat) expInstrQ.push_back(memWord(addr));
                #1;
                checks++;
                if (imem_addr !== addr) begin
                    failures++;
                    $display("[TB] FAIL fetch_addr i=%0d k=%0d: got %h expected %h", i, k, imem_addr, addr);
                end
                checks++;
                if (we !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL fetch_we i=%0d k=%0d: got %b expected 0", i, k, we);
                end
                checks++;
                if (busy !== 1'b1 || done !== 1'b0 || sel !== 1'b1) begin
                    failures++;
                    $display("[TB] FAIL fetch_status i=%0d: busy=%b done=%b sel=%b expected 1 0 1", i, busy, done, sel);
                end
                tick();
            end
            imem_valid = 1'b1;
            imem_rdata = 32'hDEAD_BEEF;
            dec_we     = decWe;
            if (i == abortIdx) reset = 1'b1;
            #1;
            exp = expInstrQ.pop_front();
            checks++;
            if (instr !== exp) begin
                failures++;
                $display("[TB] FAIL exec_instr i=%0d: got %h expected %h", i, instr, exp);
            end
            checks++;
            if (we !== (decWe && (i != abortIdx))) begin
                failures++;
                $display("[TB] FAIL exec_we i=%0d: got %b expected %b", i, we, decWe && (i != abortIdx));
            end
            if (i == abortIdx) begin
                tick();
                reset      = 1'b0;
                start      = 1'b0;
                dec_we     = 1'b1;
                imem_valid = 1'b0;
                #1;
                checks++;
                if (busy !== 1'b0 || done !== 1'b0 || we !== 1'b0 || sel !== 1'b1 || dump_valid !== 1'b0 ||
                    imem_addr !== 32'd0 || instr !== 32'd0 || instr_count !== 16'd0 || dump_rs1 !== 5'd0) begin
                    failures++;
                    $display("[TB] FAIL abort_reset: busy=%b done=%b we=%b sel=%b dv=%b addr=%h instr=%h cnt=%0d rs1=%0d expected all reset values",
                             busy, done, we, sel, dump_valid, imem_addr, instr, instr_count, dump_rs1);
                end
                dec_we = 1'b0;
                expInstrQ.delete();
                return;
            end
            tick();
            checks++;
            if (instr_count !== 16'(i + 1)) begin
                failures++;
                $display("[TB] FAIL retire_count i=%0d: got %0d expected %0d", i, instr_count, i + 1);
            end
        end
        imem_valid = 1'b0;
        dec_we     = 1'b1;
`ifdef ALU_SEQ_DUMP_EN
        for (int k = 0; k < 32; k++) begin
            #1;
            checks++;
            if (dump_valid !== 1'b1 || sel !== 1'b0 || dump_rs1 !== 5'(k) || we !== 1'b0 || busy !== 1'b1) begin
                failures++;
                $display("[TB] FAIL dump k=%0d: dv=%b sel=%b rs1=%0d we=%b busy=%b expected 1 0 %0d 0 1",
                         k, dump_valid, sel, dump_rs1, we, busy, k);
            end
            tick();
        end
`endif
        #1;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || sel !== 1'b1 || dump_valid !== 1'b0 || we !== 1'b0) begin
            failures++;
            $display("[TB] FAIL done_state: done=%b busy=%b sel=%b dv=%b we=%b expected 1 0 1 0 0",
                     done, busy, sel, dump_valid, we);
        end
        checks++;
        if (instr_count !== 16'(n)) begin
            failures++;
            $display("[TB] FAIL final_count: got %0d expected %0d", instr_count, n);
        end
        dec_we = 1'b0;
        if (!holdStart) begin
            tick();
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("[TB] FAIL back_to_idle: done=%b busy=%b expected 0 0", done, busy);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || we !== 1'b0 || sel !== 1'b1 || dump_valid !== 1'b0 ||
            imem_addr !== 32'd0 || instr !== 32'd0 || instr_count !== 16'd0 || dump_rs1 !== 5'd0) begin
            failures++;
            $display("[TB] FAIL reset_values: busy=%b done=%b we=%b sel=%b dv=%b addr=%h instr=%h cnt=%0d rs1=%0d expected reset values",
                     busy, done, we, sel, dump_valid, imem_addr, instr, instr_count, dump_rs1);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        $display("[TB] basic three-instruction run");
        run_program(3, -1, 1, 1'b1, 1'b0, -1);
    endtask

    task automatic test_stall();
        $display("[TB] second fetch stalled five cycles");
        run_program(2, 1, 5, 1'b1, 1'b0, -1);
    endtask

    task automatic test_zero_instr();
        $display("[TB] zero-instruction run");
        run_program(0, -1, 1, 1'b1, 1'b0, -1);
    endtask

    task automatic test_reset_mid_run();
        $display("[TB] reset during EXEC of instruction 2, then clean rerun");
        run_program(3, -1, 1, 1'b1, 1'b0, 1);
        run_program(2, -1, 1, 1'b1, 1'b0, -1);
    endtask

    task automatic test_start_held();
        $display("[TB] start held through DONE");
        run_program(1, -1, 1, 1'b1, 1'b1, -1);
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (done !== 1'b1 || busy !== 1'b0) begin
                failures++;
                $display("[TB] FAIL done_hold c=%0d: done=%b busy=%b expected 1 0", c, done, busy);
            end
        end
        start = 1'b0;
        tick();
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL release_start: done=%b expected 0", done);
        end
        run_program(2, 0, 3, 1'b1, 1'b0, -1);
    endtask

    task automatic test_no_write();
        $display("[TB] dec_we low on every EXEC");
        run_program(4, 2, 2, 1'b0, 1'b0, -1);
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        num_instr  = '0;
        imem_rdata = '0;
        imem_valid = 1'b0;
        dec_we     = 1'b0;
        test_reset();
        test_basic();
        test_stall();
        test_zero_instr();
        test_reset_mid_run();
        test_start_held();
        test_no_write();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
